regfile_sequencer: RTL and testbench

Command-side initiator for the processor's 16-bit register file. It accepts read/write commands from a valid/ready front end, buffers them in order in a small FIFO, drives the register file's `rw`/`w1`/`w2` port, captures read data from `r1`, and returns it on a valid/ready response port. It sits between the control/debug logic of the single-cycle processor and the register file, and replaces ad-hoc driving of the register file port.

---
 rtl/regfile_sequencer.sv | 125 ++++++++++++
 tb/tb_regfile_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command-side initiator for the 16-bit register file: queues read/write
// commands in a FIFO, drives the rw/w1/w2 port and returns read data.
module regfile_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rf_rw,
  output logic [WIDTH-1:0] rf_w1,
  output logic [WIDTH-1:0] rf_w2,
  input  logic [WIDTH-1:0] rf_r1,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t           state, state_next;
  logic             fifo_rw   [DEPTH];
  logic [WIDTH-1:0] fifo_addr [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;

  logic             rf_rw_next, rsp_valid_next;
  logic [WIDTH-1:0] rf_w1_next, rf_w2_next, rsp_data_next;

  // Full-check uses the registered count, so a push at full is refused even
  // when a pop happens on the same edge.
  assign cmd_ready = !rst && (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (count != '0) || (state != IDLE);

  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    rf_rw_next     = rf_rw;
    rf_w1_next     = rf_w1;
    rf_w2_next     = rf_w2;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    case (state)
      IDLE: begin
        rf_rw_next = 1'b0;
        if (count != '0) begin
          pop        = 1'b1;
          rf_rw_next = fifo_rw[rd_ptr];
          rf_w1_next = fifo_addr[rd_ptr];
          rf_w2_next = fifo_data[rd_ptr];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // rf_rw itself records whether the issued command is a write
        if (rf_rw) begin
          rf_rw_next = 1'b0;
          state_next = IDLE;
        end else begin
          state_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        rsp_data_next  = rf_r1;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rf_rw     <= 1'b0;
      rf_w1     <= '0;
      rf_w2     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      rf_rw     <= rf_rw_next;
      rf_w1     <= rf_w1_next;
      rf_w2     <= rf_w2_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr]   <= cmd_rw;
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed timing steps plus a random phase,
// checked against an in-order command queue and a reference register file.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [15:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rf_rw;
  logic [15:0] rf_w1, rf_w2, rf_r1;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  regfile_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rf_rw(rf_rw), .rf_w1(rf_w1), .rf_w2(rf_w2), .rf_r1(rf_r1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached register file: synchronous read, write on rw at the edge.
  logic [15:0] rf_mem [logic [15:0]];
  always @(posedge clk) begin
    rf_r1 <= rf_mem.exists(rf_w1) ? rf_mem[rf_w1] : 16'h0000;
    if (rf_rw) rf_mem[rf_w1] = rf_w2;
  end

  // Reference model: accepted commands in order, and the register contents
  // those commands imply.
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;
  cmd_t        q[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic        prev_rf_rw = 1'b0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rf_rw === 1'b1) begin
      chk("rf_rw_single_cycle", prev_rf_rw, 0);
      if (q.size() != 0 && q[0].rw) begin
        chk("wr_addr", rf_w1, q[0].addr);
        chk("wr_data", rf_w2, q[0].data);
        ref_mem[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end else begin
        chk("wr_unexpected", rf_rw, 0);
      end
    end
    prev_rf_rw = (rf_rw === 1'b1);
    if (rsp_valid === 1'b1 && rsp_ready && !rst) begin
      if (q.size() != 0 && !q[0].rw) begin
        chk("rsp_data_order", rsp_data, ref_rd(q[0].addr));
        void'(q.pop_front());
        rsp_count++;
      end else begin
        chk("rsp_unexpected", rsp_valid, 0);
      end
    end
    if (rst) q.delete();
    else if (cmd_valid && cmd_ready) q.push_back('{cmd_rw, cmd_addr, cmd_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("send_ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < limit) begin tick(); n++; end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc0;
    logic [15:0] exp0;

    // Reset held with a command offered
    rst = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h0009; cmd_data = 16'hFFFF;
    tick(); tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rf_rw", rf_rw, 0);
    chk("rst_rf_w1", rf_w1, 0);
    chk("rst_rf_w2", rf_w2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single write: rf_rw high for exactly the cycle after edge n+1
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h0003; cmd_data = 16'hA5A5;
    tick();
    cmd_valid = 1'b0;
    chk("wr_n_rf_rw", rf_rw, 0);
    chk("wr_n_busy", busy, 1);
    tick();
    chk("wr_n1_rf_rw", rf_rw, 1);
    chk("wr_n1_w1", rf_w1, 16'h0003);
    chk("wr_n1_w2", rf_w2, 16'hA5A5);
    tick();
    chk("wr_n2_rf_rw", rf_rw, 0);
    chk("wr_n2_busy", busy, 0);

    // Read latency with rsp_ready held high: valid from edge m+3 for one cycle
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0003; cmd_data = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("rd_m2_rsp_valid", rsp_valid, 0);
    tick();
    chk("rd_m3_rsp_valid", rsp_valid, 1);
    chk("rd_m3_rsp_data", rsp_data, 16'hA5A5);
    tick();
    chk("rd_m4_rsp_valid", rsp_valid, 0);

    // Write then read of the same register
    rsp_ready = 1'b0;
    send(1'b1, 16'h0005, 16'h1234);
    send(1'b0, 16'h0005, 16'h0000);
    wait_rsp(20);
    chk("wr_rd_data", rsp_data, 16'h1234);
    rsp_ready = 1'b1;
    tick();
    chk("wr_rd_released", rsp_valid, 0);
    wait_idle(20);

    // Fill behind a pending response: 4 of 5 reads accepted, none issued
    for (int i = 0; i < 5; i++) send(1'b1, 16'(10 + i), 16'($urandom));
    wait_idle(40);
    rsp_ready = 1'b0;
    send(1'b0, 16'd10, 16'h0000);
    wait_rsp(20);
    exp0 = ref_rd(16'd10);
    rc0 = rsp_count;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'(11 + i); cmd_data = 16'h0000;
      chk("fill_cmd_ready", cmd_ready, (i < 4) ? 1 : 0);
      chk("fill_rsp_valid", rsp_valid, 1);
      chk("fill_rsp_data_stable", rsp_data, exp0);
      chk("fill_no_rf_rw", rf_rw, 0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_idle(60);
    chk("fill_responses", rsp_count - rc0, 5);

    // Back-pressure: writes queued behind a stalled read must wait
    rsp_ready = 1'b0;
    send(1'b0, 16'h0003, 16'h0000);
    send(1'b1, 16'd20, 16'hBEEF);
    send(1'b1, 16'd21, 16'hCAFE);
    wait_rsp(20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_data", rsp_data, 16'hA5A5);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_no_rf_rw", rf_rw, 0);
      tick();
    end
    chk("bp_write_held", rf_mem.exists(16'd20), 0);
    rsp_ready = 1'b1;
    wait_idle(30);
    chk("bp_write20_landed", rf_mem.exists(16'd20) ? rf_mem[16'd20] : 16'h0000, 16'hBEEF);
    chk("bp_write21_landed", rf_mem.exists(16'd21) ? rf_mem[16'd21] : 16'h0000, 16'hCAFE);

    // Reset during WAIT_RD with two writes queued
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0003; cmd_data = 16'h0000;
    chk("mr_ready0", cmd_ready, 1);
    tick();
    cmd_rw = 1'b1; cmd_addr = 16'd22; cmd_data = 16'h1111;
    chk("mr_ready1", cmd_ready, 1);
    tick();
    cmd_addr = 16'd23; cmd_data = 16'h2222;
    chk("mr_ready2", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("mr_busy_before", busy, 1);
    chk("mr_no_rsp_yet", rsp_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_rf_rw", rf_rw, 0);
      chk("mr_busy", busy, 0);
      tick();
    end
    chk("mr_write_dropped", rf_mem.exists(16'd22), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_rw    = 1'($urandom_range(0, 1));
      cmd_addr  = 16'($urandom_range(0, 7));
      cmd_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("model_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
